// File: rtl/collision_pkg.sv
// collision_pkg: box types, checker states and the strict overlap rule
// shared by the collision checker and its overlap unit.
package collision_pkg;

    localparam int COLLISION_BOX_COUNT = 5;
    localparam int CW = 13;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] width;
        logic [9:0] height;
    } collision_box_t;

    // Absolute box, every field a 13-bit two's-complement value.
    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] w;
        logic [CW-1:0] h;
    } abs_box_t;

    typedef enum logic [1:0] {IDLE, OUTER, INNER, FINISH} state_t;

    function automatic logic [CW-1:0] ext_u10(input logic [9:0] v);
        return {3'b000, v};
    endfunction

    function automatic logic [CW-1:0] ext_s11(input logic [10:0] v);
        return {{2{v[10]}}, v};
    endfunction

    function automatic logic nonpos(input logic [CW-1:0] v);
        return v[CW-1] || (v == '0);
    endfunction

    // Strict overlap: touching edges and empty boxes never collide.
    function automatic logic boxes_overlap(input abs_box_t a,
                                           input abs_box_t b);
        logic signed [CW-1:0] ax, ay, aw, ah, bx, by, bw, bh;
        ax = $signed(a.x);
        ay = $signed(a.y);
        aw = $signed(a.w);
        ah = $signed(a.h);
        bx = $signed(b.x);
        by = $signed(b.y);
        bw = $signed(b.w);
        bh = $signed(b.h);
        if (nonpos(a.w) || nonpos(a.h) || nonpos(b.w) || nonpos(b.h))
            return 1'b0;
        return (ax < bx + bw) && (ax + aw > bx) &&
               (ay < by + bh) && (ay + ah > by);
    endfunction

endpackage

// File: rtl/collision_checker_box_overlap.sv
// box_overlap: combinational strict overlap test of two absolute boxes,
// shared between the coarse frame test and the per-pair sweep.
module box_overlap
    import collision_pkg::*;
(
    input  abs_box_t a,
    input  abs_box_t b,
    output logic     overlap
);

    assign overlap = boxes_overlap(a, b);

endmodule

// File: rtl/collision_checker.sv
// collision_checker: per-frame T-rex vs leftmost obstacle test; coarse
// frame test first, then one box pair per cycle, with a sticky crash flag.
module collision_checker
    import collision_pkg::*;
#(
    parameter int TREX_BOXES = 6,
    parameter int OBS_BOXES  = COLLISION_BOX_COUNT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             check,
    input  logic                             clear_crash,
    input  logic                             obs_valid,
    input  logic [10:0]                      obs_x_pos,
    input  logic [9:0]                       obs_y_pos,
    input  logic [9:0]                       obs_width,
    input  logic [9:0]                       obs_height,
    input  collision_box_t [OBS_BOXES-1:0]   obs_box,
    input  logic [9:0]                       trex_x_pos,
    input  logic [9:0]                       trex_y_pos,
    input  logic [9:0]                       trex_width,
    input  logic [9:0]                       trex_height,
    input  collision_box_t [TREX_BOXES-1:0]  trex_box,
    output logic                             busy,
    output logic                             done,
    output logic                             hit,
    output logic                             crash
);

    localparam int IW = (TREX_BOXES > 1) ? $clog2(TREX_BOXES) : 1;
    localparam int JW = (OBS_BOXES > 1) ? $clog2(OBS_BOXES) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(TREX_BOXES - 1);
    localparam logic [JW-1:0] J_LAST = JW'(OBS_BOXES - 1);

    typedef struct packed {
        logic                            obs_valid;
        logic [10:0]                     obs_x;
        logic [9:0]                      obs_y;
        logic [9:0]                      obs_w;
        logic [9:0]                      obs_h;
        collision_box_t [OBS_BOXES-1:0]  obs_box;
        logic [9:0]                      trex_x;
        logic [9:0]                      trex_y;
        logic [9:0]                      trex_w;
        logic [9:0]                      trex_h;
        collision_box_t [TREX_BOXES-1:0] trex_box;
    } snap_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  i_q, i_d;
    logic [JW-1:0]  j_q, j_d;
    logic           hit_q, hit_d;
    logic           crash_q, crash_d;
    snap_t          snap_q, snap_d;

    collision_box_t trex_sel, obs_sel;
    abs_box_t       trex_outer, obs_outer, trex_abs, obs_abs;
    abs_box_t       ov_a, ov_b;
    logic           ov;

    // Build shrunk frames and the current pair's absolute boxes; pick by state.
    always_comb begin
        trex_sel     = snap_q.trex_box[i_q];
        obs_sel      = snap_q.obs_box[j_q];
        trex_outer.x = ext_u10(snap_q.trex_x) + CW'(1);
        trex_outer.y = ext_u10(snap_q.trex_y) + CW'(1);
        trex_outer.w = ext_u10(snap_q.trex_w) - CW'(2);
        trex_outer.h = ext_u10(snap_q.trex_h) - CW'(2);
        obs_outer.x  = ext_s11(snap_q.obs_x) + CW'(1);
        obs_outer.y  = ext_u10(snap_q.obs_y) + CW'(1);
        obs_outer.w  = ext_u10(snap_q.obs_w) - CW'(2);
        obs_outer.h  = ext_u10(snap_q.obs_h) - CW'(2);
        trex_abs.x   = ext_u10(snap_q.trex_x) + ext_u10(trex_sel.x);
        trex_abs.y   = ext_u10(snap_q.trex_y) + ext_u10(trex_sel.y);
        trex_abs.w   = ext_u10(trex_sel.width);
        trex_abs.h   = ext_u10(trex_sel.height);
        obs_abs.x    = ext_s11(snap_q.obs_x) + ext_u10(obs_sel.x);
        obs_abs.y    = ext_u10(snap_q.obs_y) + ext_u10(obs_sel.y);
        obs_abs.w    = ext_u10(obs_sel.width);
        obs_abs.h    = ext_u10(obs_sel.height);
        if (state_q == OUTER) begin
            ov_a = trex_outer;
            ov_b = obs_outer;
        end else begin
            ov_a = trex_abs;
            ov_b = obs_abs;
        end
    end

    box_overlap u_overlap (
        .a       (ov_a),
        .b       (ov_b),
        .overlap (ov)
    );

    // Next state, pair sweep, snapshot capture and sticky crash (set wins).
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        hit_d   = hit_q;
        crash_d = crash_q;
        snap_d  = snap_q;
        if (clear_crash)
            crash_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (check) begin
                    state_d          = OUTER;
                    snap_d.obs_valid = obs_valid;
                    snap_d.obs_x     = obs_x_pos;
                    snap_d.obs_y     = obs_y_pos;
                    snap_d.obs_w     = obs_width;
                    snap_d.obs_h     = obs_height;
                    snap_d.obs_box   = obs_box;
                    snap_d.trex_x    = trex_x_pos;
                    snap_d.trex_y    = trex_y_pos;
                    snap_d.trex_w    = trex_width;
                    snap_d.trex_h    = trex_height;
                    snap_d.trex_box  = trex_box;
                end
            end
            OUTER: begin
                if (!snap_q.obs_valid || !ov) begin
                    state_d = FINISH;
                    hit_d   = 1'b0;
                end else begin
                    state_d = INNER;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            INNER: begin
                if (ov) begin
                    state_d = FINISH;
                    hit_d   = 1'b1;
                    crash_d = 1'b1;
                end else if (i_q == I_LAST && j_q == J_LAST) begin
                    state_d = FINISH;
                    hit_d   = 1'b0;
                end else if (j_q == J_LAST) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (hit_q)
                    crash_d = 1'b1;
            end
        endcase
    end

    // State and snapshot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            hit_q   <= 1'b0;
            crash_q <= 1'b0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            hit_q   <= hit_d;
            crash_q <= crash_d;
            snap_q  <= snap_d;
        end
    end

    assign busy  = (state_q == OUTER) || (state_q == INNER);
    assign done  = (state_q == FINISH);
    assign hit   = hit_q;
    assign crash = crash_q;

endmodule

// File: tb/tb_collision_checker.sv
// tb_collision_checker: directed cases plus randomized frames checked
// every cycle against a behavioural latency/result model.
module tb_collision_checker;
    import collision_pkg::*;

    localparam int NT = 6;
    localparam int NO = COLLISION_BOX_COUNT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic check = 1'b0;
    logic clear_crash = 1'b0;
    logic obs_valid;
    logic [10:0] obs_x_pos;
    logic [9:0] obs_y_pos, obs_width, obs_height;
    collision_box_t [NO-1:0] obs_box;
    logic [9:0] trex_x_pos, trex_y_pos, trex_width, trex_height;
    collision_box_t [NT-1:0] trex_box;
    logic busy, done, hit, crash;

    int n_tests = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    always #5 clk = ~clk;

    collision_checker #(.TREX_BOXES(NT), .OBS_BOXES(NO)) dut (
        .clk(clk), .rst(rst), .check(check), .clear_crash(clear_crash),
        .obs_valid(obs_valid), .obs_x_pos(obs_x_pos),
        .obs_y_pos(obs_y_pos), .obs_width(obs_width),
        .obs_height(obs_height), .obs_box(obs_box),
        .trex_x_pos(trex_x_pos), .trex_y_pos(trex_y_pos),
        .trex_width(trex_width), .trex_height(trex_height),
        .trex_box(trex_box), .busy(busy), .done(done), .hit(hit),
        .crash(crash)
    );

    task automatic cmp(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmpi(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_ov(input int ax, input int ay, input int aw,
                                input int ah, input int bx, input int by,
                                input int bw, input int bh);
        if (aw <= 0 || ah <= 0 || bw <= 0 || bh <= 0) return 0;
        return ax < bx + bw && ax + aw > bx && ay < by + bh && ay + ah > by;
    endfunction

    // Returns the cycle of done (check = cycle 0); r is the hit result.
    function automatic int m_eval(output bit r);
        int ox, oy, tx, ty, k;
        ox = int'($signed(obs_x_pos));
        oy = int'(obs_y_pos);
        tx = int'(trex_x_pos);
        ty = int'(trex_y_pos);
        r = 0;
        if (!obs_valid) return 2;
        if (!m_ov(tx + 1, ty + 1, int'(trex_width) - 2, int'(trex_height) - 2,
                  ox + 1, oy + 1, int'(obs_width) - 2, int'(obs_height) - 2))
            return 2;
        k = 0;
        for (int i = 0; i < NT; i++) begin
            for (int j = 0; j < NO; j++) begin
                k++;
                if (m_ov(tx + int'(trex_box[i].x), ty + int'(trex_box[i].y),
                         int'(trex_box[i].width), int'(trex_box[i].height),
                         ox + int'(obs_box[j].x), oy + int'(obs_box[j].y),
                         int'(obs_box[j].width), int'(obs_box[j].height))) begin
                    r = 1;
                    return 2 + k;
                end
            end
        end
        return 2 + k;
    endfunction

    int m_pos = 0;
    int m_lat = 2;
    bit m_res = 0;
    bit m_hit = 0;
    bit m_crash = 0;

    always @(posedge clk) begin : model
        bit set_c;
        set_c = 0;
        if (rst) begin
            m_pos = 0;
            m_hit = 0;
            m_crash = 0;
        end else begin
            if (m_pos == 0) begin
                if (check) begin
                    m_lat = m_eval(m_res);
                    m_pos = 1;
                end
            end else if (m_pos == m_lat) begin
                set_c = m_hit;
                m_pos = 0;
            end else begin
                m_pos++;
                if (m_pos == m_lat) begin
                    m_hit = m_res;
                    set_c = m_res;
                end
            end
            if (set_c) m_crash = 1;
            else if (clear_crash) m_crash = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("busy", busy, m_pos >= 1 && m_pos < m_lat);
            cmp("done", done, m_pos != 0 && m_pos == m_lat);
            cmp("hit", hit, m_hit);
            cmp("crash", crash, m_crash);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        obs_valid = 1'b1;
        obs_x_pos = '0;
        obs_y_pos = '0;
        obs_width = '0;
        obs_height = '0;
        obs_box = '0;
        trex_x_pos = '0;
        trex_y_pos = '0;
        trex_width = '0;
        trex_height = '0;
        trex_box = '0;
    endtask

    task automatic frame2();
        clear_frame();
        trex_x_pos = 10'd50;
        trex_y_pos = 10'd100;
        trex_width = 10'd44;
        trex_height = 10'd47;
        trex_box[0] = '{10'd0, 10'd0, 10'd20, 10'd20};
        obs_x_pos = 11'd60;
        obs_y_pos = 10'd105;
        obs_width = 10'd20;
        obs_height = 10'd20;
        obs_box[0] = '{10'd0, 10'd0, 10'd10, 10'd10};
    endtask

    task automatic frame3();
        clear_frame();
        trex_x_pos = 10'd50;
        trex_y_pos = 10'd100;
        trex_width = 10'd40;
        trex_height = 10'd40;
        obs_x_pos = 11'd60;
        obs_y_pos = 10'd100;
        obs_width = 10'd40;
        obs_height = 10'd40;
        for (int i = 0; i < NT; i++)
            trex_box[i] = '{10'(i * 6), 10'd0, 10'd5, 10'd5};
        for (int j = 0; j < NO; j++)
            obs_box[j] = '{10'(j * 6), 10'd30, 10'd5, 10'd5};
    endtask

    task automatic frame4(input int tbx);
        clear_frame();
        obs_x_pos = 11'(-5);
        obs_y_pos = 10'd100;
        obs_width = 10'd20;
        obs_height = 10'd10;
        obs_box[0] = '{10'd0, 10'd0, 10'd20, 10'd10};
        trex_x_pos = 10'd5;
        trex_y_pos = 10'd100;
        trex_width = 10'd40;
        trex_height = 10'd10;
        trex_box[0] = '{10'(tbx), 10'd0, 10'd20, 10'd10};
    endtask

    task automatic rand_frame();
        obs_valid = ($urandom_range(0, 7) != 0);
        obs_x_pos = 11'(int'($urandom_range(0, 300)) - 60);
        obs_y_pos = 10'($urandom_range(80, 120));
        obs_width = 10'($urandom_range(0, 60));
        obs_height = 10'($urandom_range(0, 60));
        trex_x_pos = 10'($urandom_range(20, 120));
        trex_y_pos = 10'($urandom_range(80, 120));
        trex_width = 10'($urandom_range(0, 60));
        trex_height = 10'($urandom_range(0, 60));
        for (int j = 0; j < NO; j++)
            obs_box[j] = '{10'($urandom_range(0, 40)), 10'($urandom_range(0, 40)),
                           10'($urandom_range(0, 12)), 10'($urandom_range(0, 12))};
        for (int i = 0; i < NT; i++)
            trex_box[i] = '{10'($urandom_range(0, 40)), 10'($urandom_range(0, 40)),
                            10'($urandom_range(0, 12)), 10'($urandom_range(0, 12))};
    endtask

    task automatic run_check(output int lat, output logic h,
                             output logic c, output int nb);
        check = 1'b1;
        step();
        check = 1'b0;
        lat = -1;
        h = 1'b0;
        c = 1'b0;
        nb = 0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                h = hit;
                c = crash;
                break;
            end
            if (busy) nb++;
            step();
        end
        if (lat < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no done within 64 cycles");
        end
        step();
    endtask

    task automatic pulse_clear();
        clear_crash = 1'b1;
        step();
        clear_crash = 1'b0;
    endtask

    initial begin
        int lat, nb;
        logic h, c;
        clear_frame();
        step();
        cmp_en = 1;
        step();
        rst = 1'b0;
        @(negedge clk);
        cmp("reset busy", busy, 1'b0);
        cmp("reset done", done, 1'b0);
        cmp("reset hit", hit, 1'b0);
        cmp("reset crash", crash, 1'b0);
        step();

        clear_frame();
        obs_x_pos = 11'd400;
        obs_y_pos = 10'd100;
        obs_width = 10'd20;
        obs_height = 10'd20;
        trex_x_pos = 10'd50;
        trex_y_pos = 10'd100;
        trex_width = 10'd20;
        trex_height = 10'd20;
        run_check(lat, h, c, nb);
        cmpi("t1 latency", lat, 2);
        cmp("t1 hit", h, 1'b0);
        cmp("t1 crash", c, 1'b0);

        frame2();
        run_check(lat, h, c, nb);
        cmpi("t2 latency", lat, 3);
        cmp("t2 hit", h, 1'b1);
        cmp("t2 crash", c, 1'b1);
        pulse_clear();

        frame3();
        run_check(lat, h, c, nb);
        cmpi("t3 latency", lat, 32);
        cmp("t3 hit", h, 1'b0);
        cmpi("t3 busy cycles", nb, 31);

        frame4(5);
        run_check(lat, h, c, nb);
        cmpi("t4a latency", lat, 3);
        cmp("t4a hit", h, 1'b1);
        pulse_clear();
        frame4(10);
        run_check(lat, h, c, nb);
        cmpi("t4b latency", lat, 32);
        cmp("t4b edge hit", h, 1'b0);

        frame2();
        check = 1'b1;
        step();
        check = 1'b0;
        step();
        check = 1'b1;
        clear_crash = 1'b1;
        step();
        check = 1'b0;
        clear_crash = 1'b0;
        @(negedge clk);
        cmp("t5 done", done, 1'b1);
        cmp("t5 hit", hit, 1'b1);
        cmp("t5 crash set wins", crash, 1'b1);
        step();
        clear_crash = 1'b1;
        @(negedge clk);
        cmp("t5 recheck ignored", busy, 1'b0);
        cmp("t5 crash held", crash, 1'b1);
        step();
        clear_crash = 1'b0;
        @(negedge clk);
        cmp("t5 crash cleared", crash, 1'b0);
        step();

        frame2();
        run_check(lat, h, c, nb);
        frame3();
        check = 1'b1;
        step();
        check = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        cmp("t6 busy", busy, 1'b0);
        cmp("t6 done", done, 1'b0);
        cmp("t6 crash", crash, 1'b0);
        step();
        obs_valid = 1'b0;
        run_check(lat, h, c, nb);
        cmpi("t6 latency", lat, 2);
        cmp("t6 hit", h, 1'b0);

        for (int cyc = 0; cyc < 5000; cyc++) begin
            rand_frame();
            check = ($urandom_range(0, 3) == 0);
            clear_crash = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        check = 1'b0;
        clear_crash = 1'b0;
        rst = 1'b0;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
